// File: rtl/queue_dispatcher.sv
// Dispatcher behind the random-priority scheduler. It pops the granted FWFT queue, holds the head entry
// for a valid/ready handshake, and bounds in-flight requests with credits.
// Optional per-queue acceptance counters: define QUEUE_DISPATCHER_STATS_EN.
module queue_dispatcher #(
  parameter int NUMBER_OF_QUEUES = 4,
  parameter int DATA_WIDTH       = 64,
  parameter int MAX_OUTSTANDING  = 8,
  localparam int QID_WIDTH  = $clog2(NUMBER_OF_QUEUES),
  localparam int CRED_WIDTH = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic                                   sched_valid,
  input  logic [QID_WIDTH-1:0]                   sched_sel,
  input  logic [NUMBER_OF_QUEUES-1:0]            q_empty,
  input  logic [NUMBER_OF_QUEUES*DATA_WIDTH-1:0] q_data,
  output logic [NUMBER_OF_QUEUES-1:0]            q_pop,
  output logic                                   m_valid,
  input  logic                                   m_ready,
  output logic [DATA_WIDTH-1:0]                  m_data,
  output logic [QID_WIDTH-1:0]                   m_qid,
  input  logic                                   resp_done,
  output logic [CRED_WIDTH-1:0]                  credits,
  output logic                                   busy,
  output logic                                   err_overflow
`ifdef QUEUE_DISPATCHER_STATS_EN
  ,
  output logic [NUMBER_OF_QUEUES*32-1:0]         stat_count
`endif
);

  localparam logic [CRED_WIDTH-1:0] CRED_MAX = CRED_WIDTH'(MAX_OUTSTANDING);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                                    state_q, state_d;
  logic [DATA_WIDTH-1:0]                     m_data_q;
  logic [QID_WIDTH-1:0]                      m_qid_q;
  logic [CRED_WIDTH-1:0]                     credits_q, credits_d;
  logic                                      err_q, err_d;
  logic                                      grant, acc;
  logic [NUMBER_OF_QUEUES-1:0][DATA_WIDTH-1:0] q_data_arr;

  assign q_data_arr = q_data;

  // A grant is masked during reset so no FIFO entry is popped and then lost.
  assign grant = !reset && (state_q == IDLE) && sched_valid && !q_empty[sched_sel]
                 && (credits_q != '0);
  assign acc   = (state_q == SEND) && m_ready;

  always_comb begin
    state_d = state_q;
    q_pop   = '0;
    case (state_q)
      IDLE: if (grant) begin
        state_d          = SEND;
        q_pop[sched_sel] = 1'b1;
      end
      SEND: if (m_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Simultaneous accept and completion cancel out.
  always_comb begin
    credits_d = credits_q;
    err_d     = err_q;
    if (acc && !resp_done)
      credits_d = credits_q - CRED_WIDTH'(1);
    else if (resp_done && !acc) begin
      if (credits_q == CRED_MAX) err_d = 1'b1;
      else                       credits_d = credits_q + CRED_WIDTH'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      m_data_q  <= '0;
      m_qid_q   <= '0;
      credits_q <= CRED_MAX;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      err_q     <= err_d;
      if (grant) begin
        m_data_q <= q_data_arr[sched_sel];
        m_qid_q  <= sched_sel;
      end
    end
  end

  assign m_valid      = (state_q == SEND);
  assign m_data       = m_data_q;
  assign m_qid        = m_qid_q;
  assign credits      = credits_q;
  assign busy         = (state_q != IDLE);
  assign err_overflow = err_q;

`ifdef QUEUE_DISPATCHER_STATS_EN
  logic [NUMBER_OF_QUEUES-1:0][31:0] stat_q;

  for (genvar i = 0; i < NUMBER_OF_QUEUES; i++) begin : g_stat
    always_ff @(posedge clock) begin
      if (reset)
        stat_q[i] <= '0;
      else if (acc && (m_qid_q == QID_WIDTH'(i)) && (stat_q[i] != 32'hFFFF_FFFF))
        stat_q[i] <= stat_q[i] + 32'd1;
    end
  end

  assign stat_count = stat_q;
`endif

endmodule

// File: tb/tb_queue_dispatcher.sv
// Randomized and directed bench for queue_dispatcher against a queue-based transaction model.
module tb_queue_dispatcher;
  localparam int NQ = 4, DW = 64, MO = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset, sched_valid, m_ready, resp_done;
  logic [1:0]        sched_sel;
  logic [NQ-1:0]     q_empty, q_pop;
  logic [NQ*DW-1:0]  q_data;
  logic              m_valid, busy, err_overflow;
  logic [DW-1:0]     m_data;
  logic [1:0]        m_qid;
  logic [3:0]        credits;
`ifdef QUEUE_DISPATCHER_STATS_EN
  logic [NQ*32-1:0]  stat_count;
`endif

  queue_dispatcher #(.NUMBER_OF_QUEUES(NQ), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MO)) dut (
    .clock(clock), .reset(reset), .sched_valid(sched_valid), .sched_sel(sched_sel),
    .q_empty(q_empty), .q_data(q_data), .q_pop(q_pop), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_qid(m_qid), .resp_done(resp_done), .credits(credits), .busy(busy),
    .err_overflow(err_overflow)
`ifdef QUEUE_DISPATCHER_STATS_EN
    , .stat_count(stat_count)
`endif
  );

  typedef struct { logic [DW-1:0] d; logic [1:0] q; } req_t;

  // Model: pending request (0 or 1 entries), free credits, sticky error, last registered payload.
  req_t        pend[$];
  logic [DW-1:0] fifo[NQ][$];
  int          cred;
  bit          err;
  logic [DW-1:0] last_d;
  logic [1:0]  last_q;
  longint      stat[NQ];
  int          nchk = 0, nerr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive_q();
    for (int i = 0; i < NQ; i++) begin
      q_empty[i]          = (fifo[i].size() == 0);
      q_data[i*DW +: DW]  = (fifo[i].size() == 0) ? '0 : fifo[i][0];
    end
  endtask

  task automatic model_reset();
    pend.delete();
    cred   = MO;
    err    = 1'b0;
    last_d = '0;
    last_q = '0;
    for (int i = 0; i < NQ; i++) stat[i] = 0;
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < NQ; i++) fifo[i].delete();
  endtask

  // One clock: drive, check settled outputs against the model, clock, advance the model.
  task automatic step(input bit rst, input bit sv, input logic [1:0] sel, input bit rdy, input bit done);
    bit   g, acc;
    req_t r;
    reset = rst; sched_valid = sv; sched_sel = sel; m_ready = rdy; resp_done = done;
    drive_q();
    #1;
    g = !rst && pend.size() == 0 && sv && fifo[sel].size() != 0 && cred != 0;
    chk("q_pop",   q_pop,   g ? (4'b0001 << sel) : 4'b0000);
    chk("m_valid", m_valid, pend.size() != 0);
    chk("m_data",  m_data,  pend.size() != 0 ? pend[0].d : last_d);
    chk("m_qid",   m_qid,   pend.size() != 0 ? pend[0].q : last_q);
    chk("credits", credits, cred);
    chk("busy",    busy,    pend.size() != 0);
    chk("err",     err_overflow, err);
`ifdef QUEUE_DISPATCHER_STATS_EN
    for (int i = 0; i < NQ; i++) chk("stat", stat_count[i*32 +: 32], stat[i]);
`endif
    @(posedge clock);
    #1;
    if (rst) model_reset();
    else begin
      acc = pend.size() != 0 && rdy;
      if (acc && !done) cred--;
      else if (done && !acc) begin
        if (cred == MO) err = 1'b1;
        else cred++;
      end
      if (acc) begin
        if (stat[pend[0].q] < 64'hFFFF_FFFF) stat[pend[0].q]++;
        void'(pend.pop_front());
      end
      if (g) begin
        r.d = fifo[sel][0];
        r.q = sel;
        pend.push_back(r);
        last_d = r.d;
        last_q = sel;
        void'(fifo[sel].pop_front());
      end
    end
  endtask

  initial begin
    bit   sv, rdy, done, rst;
    logic [1:0] sel;

    clear_fifos();
    reset = 1'b1; sched_valid = 0; sched_sel = 0; m_ready = 0; resp_done = 0;
    drive_q();
    @(posedge clock); #1;
    model_reset();
    step(1, 0, 0, 0, 0);
    chk("rst_credits", credits, 4'd8);

    // First grant from queue 2, then held in SEND with m_ready low.
    fifo[2].push_back(64'hA5);
    fifo[1].push_back(64'h11);
    step(0, 1, 2, 0, 0);
    chk("t1_mvalid", m_valid, 1'b1);
    chk("t1_mdata",  m_data,  64'hA5);
    chk("t1_mqid",   m_qid,   2'd2);
    for (int k = 0; k < 5; k++) step(0, 1, 1, 0, 0);
    chk("t2_cred_hold", credits, 4'd8);
    step(0, 1, 1, 1, 0);
    chk("t2_cred_acc", credits, 4'd7);

    // Exhaust credits, then one completion re-enables a grant.
    clear_fifos();
    step(1, 0, 0, 0, 0);
    for (int k = 0; k < 10; k++) fifo[0].push_back(64'h100 + k);
    for (int k = 0; k < 16; k++) step(0, 1, 0, 1, 0);
    chk("t3_cred0", credits, 4'd0);
    for (int k = 0; k < 3; k++) step(0, 1, 0, 1, 0);
    chk("t3_no_send", m_valid, 1'b0);
    step(0, 1, 0, 1, 1);
    chk("t3_cred1", credits, 4'd1);
    step(0, 1, 0, 0, 0);
    chk("t3_regrant", m_valid, 1'b1);

    // Completion with all credits free sets the sticky error.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("t4_err", err_overflow, 1'b1);
    chk("t4_cred", credits, 4'd8);

    // Scheduler glitch: selected queue empty.
    clear_fifos();
    step(1, 0, 0, 0, 0);
    fifo[0].push_back(64'h55);
    step(0, 1, 1, 1, 0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_err",  err_overflow, 1'b0);

    // Reset during SEND with credits=6, then three accepts from queue 3.
    for (int k = 0; k < 6; k++) fifo[3].push_back(64'h300 + k);
    for (int k = 0; k < 4; k++) step(0, 1, 3, 1, 0);
    step(0, 1, 3, 0, 0);
    chk("t6_cred6", credits, 4'd6);
    chk("t6_send",  m_valid, 1'b1);
    step(1, 1, 3, 0, 0);
    chk("t6_mvalid", m_valid, 1'b0);
    chk("t6_busy",   busy, 1'b0);
    chk("t6_cred",   credits, 4'd8);
    for (int k = 0; k < 6; k++) step(0, 1, 3, 1, 0);
`ifdef QUEUE_DISPATCHER_STATS_EN
    chk("t6_stat3", stat_count[3*32 +: 32], 32'd3);
`endif

    // Random traffic.
    clear_fifos();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NQ; i++)
        if (fifo[i].size() < 4 && $urandom_range(2) == 0)
          fifo[i].push_back({$urandom, $urandom});
      sv = 1'b0;
      for (int i = 0; i < NQ; i++) if (fifo[i].size() != 0) sv = 1'b1;
      if ($urandom_range(9) == 0) sv = ~sv;
      sel  = 2'($urandom_range(3));
      rdy  = $urandom_range(3) != 0;
      done = ($urandom_range(2) == 0) && (cred < MO || $urandom_range(19) == 0);
      rst  = $urandom_range(499) == 0;
      step(rst, sv, sel, rdy, done);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
